// File: rtl/sim_controller.sv
// Calibrating step/dir controller for a simulated stepper axis.
// Seeks both limits, then follows the simulator's per-tick step deltas.
module sim_controller #(
    parameter int unsigned STEP_PERIOD   = 1000,
    parameter int unsigned STEP_WIDTH    = 100,
    parameter int unsigned CALIB_TIMEOUT = 4000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic               sync_sim_clock,
    input  logic               end_left,
    input  logic               end_right,
    input  logic signed [15:0] delta_steps,
    output logic               calib,
    output logic               step,
    output logic               dir,
    output logic [2:0]         state,
    output logic               calib_done,
    output logic               overrun,
    output logic               fault
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEEK_RIGHT = 3'd1,
        SEEK_LEFT  = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_e;

    localparam logic [15:0] PER = 16'(STEP_PERIOD);
    localparam logic [15:0] WID = 16'(STEP_WIDTH);
    localparam logic [15:0] TMO = 16'(CALIB_TIMEOUT);

    state_e      state_q, state_d;
    logic        sync_q, live_q;
    logic [15:0] tcnt_q, tcnt_inc;
    logic [16:0] rem_q, rem_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        busy_q, busy_d;
    logic        hi_q, hi_d;
    logic        mute_q, mute_d;
    logic        dir_q, dir_d;
    logic        step_q, calib_q, done_q, fault_q, ovr_q;
    logic        tick, seeking, load, abort, timeout;
    logic [16:0] mag, ld_val;

    // live_q masks the first clock after reset so a high sync is not a tick
    assign tick     = sync_sim_clock & ~sync_q & live_q;
    assign tcnt_inc = tcnt_q + 16'd1;
    assign seeking  = (state_q == SEEK_RIGHT) || (state_q == SEEK_LEFT);
    assign timeout  = tick && (tcnt_inc == TMO);

    assign mag = delta_steps[15] ? (17'd0 - {1'b1, delta_steps})
                                 : {1'b0, delta_steps};
    assign ld_val = (state_q == RUN) ? mag : 17'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = SEEK_RIGHT;
            SEEK_RIGHT: begin
                if (end_right)    state_d = SEEK_LEFT;
                else if (timeout) state_d = FAULT;
            end
            SEEK_LEFT:  begin
                if (end_left)     state_d = RUN;
                else if (timeout) state_d = FAULT;
            end
            RUN:        state_d = RUN;
            FAULT:      if (clear) state_d = IDLE;
            default:    state_d = FAULT;
        endcase
        if (end_left && end_right && state_q != FAULT) state_d = FAULT;
    end

    assign load  = tick && (state_d == state_q) && (seeking || state_q == RUN);
    assign abort = (state_d != state_q) &&
                   !(state_q == SEEK_LEFT && state_d == RUN);

    always_comb begin
        rem_d  = rem_q;
        busy_d = busy_q;
        pcnt_d = pcnt_q;
        hi_d   = hi_q;
        mute_d = mute_q;
        dir_d  = dir_q;
        if (state_d == SEEK_RIGHT) dir_d = 1'b1;
        else if (state_d == SEEK_LEFT) dir_d = 1'b0;
        else if (load && delta_steps != 16'sd0) dir_d = ~delta_steps[15];
        if (busy_q) begin
            pcnt_d = pcnt_q + 16'd1;
            if (pcnt_q == WID - 16'd1) hi_d = 1'b0;
            if (pcnt_q == PER - 16'd1) busy_d = 1'b0;
        end
        // a fresh tick value takes priority; the pulse starts one clock later
        if (load) begin
            rem_d = ld_val;
        end else if (rem_q != 17'd0 && (!busy_q || pcnt_q == PER - 16'd1)) begin
            rem_d  = rem_q - 17'd1;
            busy_d = 1'b1;
            pcnt_d = 16'd0;
            hi_d   = 1'b1;
            mute_d = (state_d == RUN) && (dir_d ? end_right : end_left);
        end
        if (abort) begin
            rem_d  = 17'd0;
            busy_d = 1'b0;
            pcnt_d = 16'd0;
            hi_d   = 1'b0;
            mute_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            sync_q  <= 1'b0;
            live_q  <= 1'b0;
            tcnt_q  <= 16'd0;
            rem_q   <= 17'd0;
            pcnt_q  <= 16'd0;
            busy_q  <= 1'b0;
            hi_q    <= 1'b0;
            mute_q  <= 1'b0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            calib_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_sim_clock;
            live_q  <= 1'b1;
            if (state_d != state_q || !seeking) tcnt_q <= 16'd0;
            else if (tick) tcnt_q <= tcnt_inc;
            rem_q   <= rem_d;
            pcnt_q  <= pcnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            mute_q  <= mute_d;
            dir_q   <= dir_d;
            step_q  <= hi_d & ~mute_d & (state_d != FAULT);
            calib_q <= (state_d == SEEK_RIGHT) || (state_d == SEEK_LEFT);
            done_q  <= (state_d == RUN);
            fault_q <= (state_d == FAULT);
            if (load && state_q == RUN && rem_q != 17'd0) ovr_q <= 1'b1;
        end
    end

    assign calib      = calib_q;
    assign step       = step_q;
    assign dir        = dir_q;
    assign state      = state_q;
    assign calib_done = done_q;
    assign overrun    = ovr_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_sim_controller.sv
// Bench for sim_controller: directed scenarios, pulse scoreboard.
// Expected pulses are queued by the stimulus and popped by a monitor.
module tb_sim_controller;

    logic clk = 1'b0;
    logic reset, start, clear, sync_sim_clock, end_left, end_right;
    logic signed [15:0] delta_steps;
    logic calib, step, dir, calib_done, overrun, fault;
    logic [2:0] state;

    sim_controller #(
        .STEP_PERIOD(10),
        .STEP_WIDTH(4),
        .CALIB_TIMEOUT(8)
    ) dut (
        .clock(clk),
        .reset(reset),
        .start(start),
        .clear(clear),
        .sync_sim_clock(sync_sim_clock),
        .end_left(end_left),
        .end_right(end_right),
        .delta_steps(delta_steps),
        .calib(calib),
        .step(step),
        .dir(dir),
        .state(state),
        .calib_done(calib_done),
        .overrun(overrun),
        .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        d;
        logic [31:0] w;
    } exp_t;

    exp_t        sb_q[$];
    int          rise_q[$];
    int          pcyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        in_p = 1'b0;
    logic        rdir = 1'b0;
    int          hw = 0;
    int          p0;
    bit          seen;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic expect_pulses(input int n, input logic d, input int w);
        exp_t e;
        e.d = d;
        e.w = 32'(w);
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    task automatic do_tick(input int gap);
        sync_sim_clock = 1'b1;
        @(negedge clk);
        sync_sim_clock = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // monitor: measures each step pulse and scores it against the queue
    always @(negedge clk) begin
        exp_t e;
        if (step && !in_p) begin
            in_p = 1'b1;
            hw   = 1;
            rdir = dir;
            rise_q.push_back(pcyc);
        end else if (step) begin
            hw++;
        end else if (in_p) begin
            in_p = 1'b0;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=dir%0d/w%0d required=none",
                         rdir, hw);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_dir", int'(rdir), int'(e.d));
                chk("pulse_width", hw, int'(e.w));
            end
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        sync_sim_clock = 1'b0;
        end_left = 1'b0;
        end_right = 1'b0;
        delta_steps = 16'sd0;
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_calib", int'(calib), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_done", int'(calib_done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_fault", int'(fault), 0);
        reset = 1'b1;
        @(negedge clk);

        // calibration: 5 right pulses, then 7 left pulses
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("seekr_state", int'(state), 1);
        chk("seekr_calib", int'(calib), 1);
        chk("seekr_dir", int'(dir), 1);
        expect_pulses(5, 1'b1, 4);
        for (int i = 0; i < 5; i++) do_tick(15);
        end_right = 1'b1;
        @(negedge clk);
        end_right = 1'b0;
        chk("seekl_state", int'(state), 2);
        chk("seekl_calib", int'(calib), 1);
        chk("seekl_dir", int'(dir), 0);
        expect_pulses(7, 1'b0, 4);
        for (int i = 0; i < 7; i++) do_tick(15);
        end_left = 1'b1;
        @(negedge clk);
        end_left = 1'b0;
        chk("run_state", int'(state), 3);
        chk("run_done", int'(calib_done), 1);
        chk("run_calib", int'(calib), 0);
        chk("calib_left", sb_q.size(), 0);

        // negative delta: 3 pulses toward left, period 10
        delta_steps = -16'sd3;
        rise_q.delete();
        p0 = pcyc;
        expect_pulses(3, 1'b0, 4);
        do_tick(35);
        chk("neg_dir", int'(dir), 0);
        chk("neg_rises", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            chk("neg_latency", rise_q[0] - p0, 2);
            chk("neg_period1", rise_q[1] - rise_q[0], 10);
            chk("neg_period2", rise_q[2] - rise_q[1], 10);
        end
        chk("neg_left", sb_q.size(), 0);
        chk("neg_overrun", int'(overrun), 0);

        // overrun: 3 pulses of +50 begun, then +2 replaces backlog
        delta_steps = 16'sd50;
        expect_pulses(5, 1'b1, 4);
        do_tick(23);
        delta_steps = 16'sd2;
        do_tick(40);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_left", sb_q.size(), 0);
        chk("ovr_state", int'(state), 3);

        // limit masking then double-limit fault
        end_right = 1'b1;
        delta_steps = 16'sd4;
        do_tick(50);
        chk("mask_dir", int'(dir), 1);
        chk("mask_step", int'(step), 0);
        chk("mask_left", sb_q.size(), 0);
        end_left = 1'b1;
        @(negedge clk);
        chk("both_state", int'(state), 4);
        chk("both_fault", int'(fault), 1);
        chk("both_step", int'(step), 0);
        end_left = 1'b0;
        end_right = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fault_start_ign", int'(state), 4);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_state", int'(state), 0);
        chk("clear_fault", int'(fault), 0);

        // seek timeout after 8 ticks with no limit
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_pulses(7, 1'b1, 4);
        for (int i = 0; i < 7; i++) do_tick(15);
        chk("tmo_pre_state", int'(state), 1);
        do_tick(2);
        chk("tmo_state", int'(state), 4);
        chk("tmo_fault", int'(fault), 1);
        chk("tmo_step", int'(step), 0);
        chk("tmo_calib", int'(calib), 0);
        chk("tmo_left", sb_q.size(), 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("tmo_clear", int'(state), 0);

        // reset in the middle of a RUN pulse
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        end_right = 1'b1;
        @(negedge clk);
        end_right = 1'b0;
        end_left = 1'b1;
        @(negedge clk);
        end_left = 1'b0;
        chk("rr_state", int'(state), 3);
        delta_steps = 16'sd3;
        expect_pulses(1, 1'b1, 1);
        sync_sim_clock = 1'b1;
        @(negedge clk);
        sync_sim_clock = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (step) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL rr_wait_step actual=none required=rise");
        end
        reset = 1'b0;
        @(negedge clk);
        chk("rr_step", int'(step), 0);
        chk("rr_state0", int'(state), 0);
        chk("rr_overrun", int'(overrun), 0);
        chk("rr_done", int'(calib_done), 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("final_left", sb_q.size(), 0);
        chk("final_step", int'(step), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
